mpu_ifetch_queue: RTL and testbench



---
 rtl/mpu_ifetch_queue.sv | 115 +++++++++++
 tb/tb_mpu_ifetch_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_ifetch_queue.sv
// Instruction prefetch queue for the MPU: issues sequential word fetches to the
// program RAM controller and buffers {pc, inst} pairs for the CPU fetch stage.
module mpu_ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      redirect,
    input  logic [31:0]               redirect_pc,
    output logic                      fetch_valid,
    input  logic                      fetch_ready,
    output logic [31:0]               fetch_pc,
    output logic [31:0]               fetch_inst,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      iBus_cmd_valid,
    input  logic                      iBus_cmd_ready,
    output logic [31:0]               iBus_cmd_payload_pc,
    input  logic                      iBus_rsp_valid,
    input  logic [31:0]               iBus_rsp_payload_inst
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   tag_q, tag_d;
    logic          inflight_q, inflight_d;
    logic          discard_q, discard_d;
    logic [AW:0]   occ_q, occ_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   ent_pc_q [DEPTH];
    logic [31:0]   ent_pc_d [DEPTH];
    logic [31:0]   ent_inst_q [DEPTH];
    logic [31:0]   ent_inst_d [DEPTH];

    logic [AW+1:0] credit_sum;
    logic          accept;
    logic          push;
    logic          pop;

    // Credit counts the outstanding request so a full queue can never overflow.
    assign credit_sum          = {1'b0, occ_q} + (AW+2)'(inflight_q);
    assign iBus_cmd_valid      = reset_n & ~redirect & (credit_sum < DEPTH_W);
    assign iBus_cmd_payload_pc = pc_q;
    assign accept              = iBus_cmd_valid & iBus_cmd_ready;

    assign fetch_valid = (occ_q != '0);
    assign fetch_pc    = fetch_valid ? ent_pc_q[rd_ptr_q]   : 32'h0;
    assign fetch_inst  = fetch_valid ? ent_inst_q[rd_ptr_q] : 32'h0;
    assign occupancy   = occ_q;

    assign push = iBus_rsp_valid & inflight_q & ~discard_q & ~redirect;
    assign pop  = fetch_valid & fetch_ready & ~redirect;

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = accept;
        discard_d  = 1'b0;
        occ_d      = occ_q + (AW+1)'(push) - (AW+1)'(pop);
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        ent_pc_d   = ent_pc_q;
        ent_inst_d = ent_inst_q;

        if (accept) begin
            tag_d = pc_q;
            pc_d  = pc_q + 32'd4;
        end
        if (push) begin
            ent_pc_d[wr_ptr_q]   = tag_q;
            ent_inst_d[wr_ptr_q] = iBus_rsp_payload_inst;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // A response concurrent with the redirect is already blocked; discard
        // covers the single following cycle so a late strobe cannot slip in.
        if (redirect) begin
            occ_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            pc_d       = {redirect_pc[31:2], 2'b00};
            discard_d  = inflight_q;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= {RESET_PC[31:2], 2'b00};
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            occ_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by occupancy.
    always_ff @(posedge clk) begin
        tag_q      <= tag_d;
        ent_pc_q   <= ent_pc_d;
        ent_inst_q <= ent_inst_d;
    end
endmodule

// File: tb/tb_mpu_ifetch_queue.sv
// Bench for mpu_ifetch_queue: directed scenarios plus randomized traffic against
// a queue-based reference model and a one-cycle-latency controller model.
module tb_mpu_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic [2:0]  occupancy;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_pc;
    logic        rsp_valid;
    logic [31:0] rsp_inst;

    mpu_ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .redirect              (redirect),
        .redirect_pc           (redirect_pc),
        .fetch_valid           (fetch_valid),
        .fetch_ready           (fetch_ready),
        .fetch_pc              (fetch_pc),
        .fetch_inst            (fetch_inst),
        .occupancy             (occupancy),
        .iBus_cmd_valid        (cmd_valid),
        .iBus_cmd_ready        (cmd_ready),
        .iBus_cmd_payload_pc   (cmd_pc),
        .iBus_rsp_valid        (rsp_valid),
        .iBus_rsp_payload_inst (rsp_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_tag;
    bit          m_inflight;
    bit          m_discard;
    bit          model_ok = 0;
    bit          pending  = 0;
    logic [31:0] pend_pc  = 32'h0;
    bit          spur_en  = 0;
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive controller response, compare, advance model.
    task automatic tick(input bit force_spur = 0);
        bit          spur;
        bit          exp_cv;
        bit          dut_acc;
        logic [31:0] dut_pc;
        spur      = !pending && (force_spur || (spur_en && ($urandom_range(3) == 0)));
        rsp_valid = pending || spur;
        rsp_inst  = pending ? inst_of(pend_pc) : $urandom;
        #1;
        exp_cv = reset_n && !redirect && (mq.size() + int'(m_inflight) < DEPTH);
        if (model_ok) begin
            chk("cmd_valid", 32'(cmd_valid), 32'(exp_cv));
            chk("cmd_pc", cmd_pc, m_pc);
            chk("fetch_valid", 32'(fetch_valid), 32'(mq.size() != 0));
            chk("occupancy", 32'(occupancy), 32'(mq.size()));
            if (mq.size() != 0) begin
                chk("fetch_pc", fetch_pc, mq[0].pc);
                chk("fetch_inst", fetch_inst, mq[0].inst);
            end
        end
        dut_acc = cmd_valid && cmd_ready;
        dut_pc  = cmd_pc;
        @(posedge clk);
        if (!reset_n) begin
            mq.delete();
            m_pc       = RESET_PC & ~32'h3;
            m_inflight = 0;
            m_discard  = 0;
            model_ok   = 1;
        end else if (redirect) begin
            mq.delete();
            m_pc       = redirect_pc & ~32'h3;
            m_discard  = m_inflight;
            m_inflight = 0;
        end else begin
            if (mq.size() != 0 && fetch_ready) void'(mq.pop_front());
            if (rsp_valid && m_inflight && !m_discard) mq.push_back('{m_tag, rsp_inst});
            m_discard = 0;
            if (exp_cv && cmd_ready) begin
                m_tag      = m_pc;
                m_pc       = m_pc + 32'd4;
                m_inflight = 1;
            end else begin
                m_inflight = 0;
            end
        end
        pending = dut_acc;
        pend_pc = dut_pc;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit fr);
        reset_n     = 1'b0;
        fetch_ready = fr;
        tick();
        reset_n = 1'b1;
    endtask

    logic [31:0] held_pc;

    initial begin
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        fetch_ready = 1'b1;
        cmd_ready   = 1'b1;
        rsp_valid   = 1'b0;
        rsp_inst    = 32'h0;

        // Reset state and first stream from RESET_PC
        tick();
        tick();
        chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        chk("rst_fetch_pc", fetch_pc, 32'h0);
        chk("rst_fetch_inst", fetch_inst, 32'h0);
        reset_n = 1'b1;
        tick();
        chk("lat1_fetch_valid", 32'(fetch_valid), 32'h0);
        chk("lat1_cmd_pc", cmd_pc, 32'h4);
        tick();
        chk("lat2_fetch_valid", 32'(fetch_valid), 32'h1);
        chk("lat2_fetch_pc", fetch_pc, 32'h0);
        chk("lat2_fetch_inst", fetch_inst, inst_of(32'h0));
        tick();
        chk("stream_pc4", fetch_pc, 32'h4);
        tick();
        chk("stream_pc8", fetch_pc, 32'h8);
        chk("stream_inst8", fetch_inst, inst_of(32'h8));

        // Controller stall for three cycles
        cmd_ready = 1'b0;
        held_pc   = cmd_pc;
        chk("stall_start_pc", held_pc, 32'h10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc_stable", cmd_pc, held_pc);
        end
        cmd_ready = 1'b1;
        tick();
        tick();
        chk("after_stall_pc10", fetch_pc, 32'h10);
        tick();
        chk("after_stall_pc14", fetch_pc, 32'h14);

        // Redirect while CPU is consuming a valid head
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        chk("redir_occ", 32'(occupancy), 32'h0);
        chk("redir_fetch_valid", 32'(fetch_valid), 32'h0);
        chk("redir_cmd_pc", cmd_pc, 32'h200);
        tick();
        tick();
        chk("redir_head", fetch_pc, 32'h200);

        // PC wrap at the top of the address space, then reset mid-stream
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        chk("wrap_pc0", cmd_pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap_pc1", cmd_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc2", cmd_pc, 32'h0000_0000);
        chk("wrap_head", fetch_pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap_head2", fetch_pc, 32'hFFFF_FFFC);
        do_reset(1'b1);
        chk("midrst_occ", 32'(occupancy), 32'h0);
        chk("midrst_fetch_valid", 32'(fetch_valid), 32'h0);
        chk("midrst_cmd_pc", cmd_pc, 32'h0);
        tick(1'b1);
        chk("midrst_spur_ignored", 32'(occupancy), 32'h0);

        // Queue fills to DEPTH with the CPU stalled
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("full_occ", 32'(occupancy), 32'h4);
        chk("full_cmd_valid", 32'(cmd_valid), 32'h0);
        chk("full_cmd_pc", cmd_pc, 32'h10);
        chk("full_head", fetch_pc, 32'h0);
        fetch_ready = 1'b1;
        tick();
        chk("drain_head4", fetch_pc, 32'h4);
        chk("drain_resume_cv", 32'(cmd_valid), 32'h1);
        tick();
        chk("drain_head8", fetch_pc, 32'h8);
        tick();
        chk("drain_headC", fetch_pc, 32'hC);
        tick();
        chk("drain_head10", fetch_pc, 32'h10);

        // Redirect with one request in flight and two entries queued
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) tick();
        chk("pre_redir_occ", 32'(occupancy), 32'h2);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect    = 1'b0;
        fetch_ready = 1'b1;
        chk("stale_occ", 32'(occupancy), 32'h0);
        chk("stale_cmd_pc", cmd_pc, 32'h100);
        tick();
        chk("stale_dropped", 32'(fetch_valid), 32'h0);
        tick();
        chk("stale_new_head", fetch_pc, 32'h100);
        chk("stale_new_inst", fetch_inst, inst_of(32'h100));

        // Randomized traffic
        spur_en = 1;
        for (int i = 0; i < 3000; i++) begin
            cmd_ready   = ($urandom_range(3) != 0);
            fetch_ready = ($urandom_range(4) > 1);
            redirect    = ($urandom_range(31) == 0);
            redirect_pc = $urandom;
            reset_n     = ($urandom_range(199) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
